// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//   Built-in self-test sequencer for the 32x32 RegisterFile. A run writes
//   pattern(r) = PATTERN_BASE + r into registers FIRST_REG..LAST_REG, one per
//   clock, then reads them back two per clock through both read ports. It
//   counts mismatching ports and remembers the first failing register.
//   The RegisterFile reads combinationally and commits writes on the Clk edge.
//
// Ports
//   Clk, Reset        clock (rising edge), synchronous active-low reset
//   Start             begin a run; only looked at in IDLE or DONE
//   Busy              high while writing or reading back
//   Done              high once a run has finished, held until Start/Reset
//   Pass              valid with Done; 1 when no port mismatched
//   ErrCount[5:0]     mismatching ports, saturating at 63
//   FirstErrReg[4:0]  register of the first mismatch, 0 when none
//   WriteRegister, WriteData, RegWrite        RegisterFile write port
//   ReadRegister1/2 (out), ReadData1/2 (in)   RegisterFile read ports
// -----------------------------------------------------------------------------
module regfile_bist #(
  parameter int          FIRST_REG    = 8,
  parameter int          LAST_REG     = 25,
  parameter logic [31:0] PATTERN_BASE = 32'hA5A5_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [5:0]  ErrCount,
  output logic [4:0]  FirstErrReg,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);
  // A single-register range reads the same register on both ports.
  localparam logic [4:0] FIRST_R2 = (FIRST_REG + 1 > LAST_REG) ? LAST_A : 5'(FIRST_REG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] pattern(input logic [4:0] r);
    return PATTERN_BASE + {27'd0, r};
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [1:0] inc);
    logic [6:0] s;
    s = {1'b0, a} + {5'd0, inc};
    return (s > 7'd63) ? 6'd63 : s[5:0];
  endfunction

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [5:0]  err_cnt_q, err_cnt_d;
  logic [4:0]  first_err_q, first_err_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rreg1_q, rreg1_d;
  logic [4:0]  rreg2_q, rreg2_d;

  logic        mism1, mism2, dup_pair, err1, err2;
  logic [1:0]  err_inc;
  logic [5:0]  r2_next_wide;

  always_comb begin
    mism1    = (ReadData1 != pattern(rreg1_q));
    mism2    = (ReadData2 != pattern(rreg2_q));
    dup_pair = (rreg1_q == rreg2_q);
    // On the duplicated last pair a failure counts once, attributed to port 1.
    err1     = mism1 | (dup_pair & mism2);
    err2     = mism2 & ~dup_pair;
    err_inc  = {1'b0, err1} + {1'b0, err2};
    r2_next_wide = {1'b0, rreg1_q} + 6'd3;

    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    regwrite_d  = regwrite_q;
    rreg1_d     = rreg1_q;
    rreg2_d     = rreg2_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d     = S_WRITE;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_cnt_d   = 6'd0;
          first_err_d = 5'd0;
          wreg_d      = FIRST_A;
          wdata_d     = pattern(FIRST_A);
          regwrite_d  = 1'b1;
        end
      end

      S_WRITE: begin
        if (wreg_q == LAST_A) begin
          state_d    = S_READ;
          regwrite_d = 1'b0;
          wreg_d     = 5'd0;
          wdata_d    = 32'd0;
          rreg1_d    = FIRST_A;
          rreg2_d    = FIRST_R2;
        end else begin
          wreg_d  = wreg_q + 5'd1;
          wdata_d = pattern(wreg_q + 5'd1);
        end
      end

      S_READ: begin
        err_cnt_d = sat_add(err_cnt_q, err_inc);
        // A zero count means nothing has failed yet in this run.
        if ((err_cnt_q == 6'd0) && (err1 || err2)) begin
          first_err_d = err1 ? rreg1_q : rreg2_q;
        end
        if (rreg2_q == LAST_A) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == 6'd0) && !err1 && !err2;
          rreg1_d = 5'd0;
          rreg2_d = 5'd0;
        end else begin
          rreg1_d = rreg1_q + 5'd2;
          rreg2_d = (r2_next_wide > {1'b0, LAST_A}) ? LAST_A : r2_next_wide[4:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 6'd0;
      first_err_q <= 5'd0;
      wreg_q      <= 5'd0;
      wdata_q     <= 32'd0;
      regwrite_q  <= 1'b0;
      rreg1_q     <= 5'd0;
      rreg2_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      regwrite_q  <= regwrite_d;
      rreg1_q     <= rreg1_d;
      rreg2_q     <= rreg2_d;
    end
  end

  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Pass          = pass_q;
  assign ErrCount      = err_cnt_q;
  assign FirstErrReg   = first_err_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = regwrite_q;
  assign ReadRegister1 = rreg1_q;
  assign ReadRegister2 = rreg2_q;

endmodule

// File: tb/tb_regfile_bist.sv
// -----------------------------------------------------------------------------
// tb_regfile_bist
//   Drives two sequencers (default range 8..25 and a short odd range 8..12),
//   each attached to a behavioural RegisterFile with per-register stuck-at-0
//   masks, and checks traces and results against expectations derived from the
//   register range and the injected faults.
// -----------------------------------------------------------------------------
module tb_regfile_bist;

  localparam logic [31:0] PB = 32'hA5A5_0000;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;
  logic start_a, start_b;
  logic scramble;

  logic        busy_a, done_a, pass_a, regw_a;
  logic [5:0]  ec_a;
  logic [4:0]  fe_a, wreg_a, rr1_a, rr2_a;
  logic [31:0] wdata_a, rd1_a, rd2_a;

  logic        busy_b, done_b, pass_b, regw_b;
  logic [5:0]  ec_b;
  logic [4:0]  fe_b, wreg_b, rr1_b, rr2_b;
  logic [31:0] wdata_b, rd1_b, rd2_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] mask_a [32];
  logic [31:0] mask_b [32];

  regfile_bist dut_a (
    .Clk(Clk), .Reset(Reset), .Start(start_a),
    .Busy(busy_a), .Done(done_a), .Pass(pass_a),
    .ErrCount(ec_a), .FirstErrReg(fe_a),
    .WriteRegister(wreg_a), .WriteData(wdata_a), .RegWrite(regw_a),
    .ReadRegister1(rr1_a), .ReadRegister2(rr2_a),
    .ReadData1(rd1_a), .ReadData2(rd2_a)
  );

  regfile_bist #(.FIRST_REG(8), .LAST_REG(12), .PATTERN_BASE(PB)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(start_b),
    .Busy(busy_b), .Done(done_b), .Pass(pass_b),
    .ErrCount(ec_b), .FirstErrReg(fe_b),
    .WriteRegister(wreg_b), .WriteData(wdata_b), .RegWrite(regw_b),
    .ReadRegister1(rr1_b), .ReadRegister2(rr2_b),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  // Behavioural RegisterFile: reg 0 reads zero, writes commit on the edge,
  // stuck-at-0 faults applied on read. Scramble fills with random junk so a
  // missing write cannot go unnoticed.
  always @(posedge Clk) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= $urandom;
        mem_b[i] <= $urandom;
      end
    end else begin
      if (regw_a && wreg_a != 5'd0) mem_a[wreg_a] <= wdata_a;
      if (regw_b && wreg_b != 5'd0) mem_b[wreg_b] <= wdata_b;
    end
  end

  assign rd1_a = (rr1_a == 5'd0) ? 32'd0 : (mem_a[rr1_a] & ~mask_a[rr1_a]);
  assign rd2_a = (rr2_a == 5'd0) ? 32'd0 : (mem_a[rr2_a] & ~mask_a[rr2_a]);
  assign rd1_b = (rr1_b == 5'd0) ? 32'd0 : (mem_b[rr1_b] & ~mask_b[rr1_b]);
  assign rd2_b = (rr2_b == 5'd0) ? 32'd0 : (mem_b[rr2_b] & ~mask_b[rr2_b]);

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  ec;
    logic [4:0]  fe;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        regw;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
  } obs_t;

  typedef struct {
    int sel;
    int r1, b1, r2, b2;   // fault sites; register 0 means none
    int exp_pass, exp_ec, exp_fe;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.busy = busy_a; o.done = done_a; o.pass = pass_a; o.ec = ec_a; o.fe = fe_a;
      o.wreg = wreg_a; o.wdata = wdata_a; o.regw = regw_a; o.rr1 = rr1_a; o.rr2 = rr2_a;
    end else begin
      o.busy = busy_b; o.done = done_b; o.pass = pass_b; o.ec = ec_b; o.fe = fe_b;
      o.wreg = wreg_b; o.wdata = wdata_b; o.regw = regw_b; o.rr1 = rr1_b; o.rr2 = rr2_b;
    end
    return o;
  endfunction

  function automatic logic [31:0] pat(input int r);
    return PB + 32'(r);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic clear_masks();
    for (int i = 0; i < 32; i++) begin
      mask_a[i] = 32'd0;
      mask_b[i] = 32'd0;
    end
  endtask

  task automatic add_fault(input int sel, input int r, input int b);
    if (r != 0) begin
      if (sel == 0) mask_a[r] = mask_a[r] | (32'd1 << b);
      else          mask_b[r] = mask_b[r] | (32'd1 << b);
    end
  endtask

  // Expected result of a run: every tested register whose pattern loses a bit
  // to a stuck-at-0 counts once; the lowest such register is reported first.
  task automatic model(input int sel, input int first, input int last,
                       output int ec, output int fe);
    logic [31:0] m;
    ec = 0;
    fe = 0;
    for (int r = first; r <= last; r++) begin
      m = (sel == 0) ? mask_a[r] : mask_b[r];
      if ((pat(r) & m) != 32'd0) begin
        if (ec == 0) fe = r;
        ec++;
      end
    end
    if (ec > 63) ec = 63;
  endtask

  task automatic scramble_mem();
    scramble = 1'b1;
    @(posedge Clk); #1;
    scramble = 1'b0;
  endtask

  // One complete run with a cycle-by-cycle trace check. The bound on the loop
  // is the expected Done edge, so a late or early Done shows up as a trace error.
  task automatic run_check(input int sel, input int first, input int last,
                           input int exp_pass, input int exp_ec, input int exp_fe,
                           input bit noise, input string tag);
    int n, d, noise_k, j;
    int e_busy, e_done, e_regw, e_wreg, e_rr1, e_rr2;
    logic [31:0] e_wdata;
    bit trace_ok;
    obs_t o;
    n = last - first + 1;
    d = n + (n + 1) / 2;
    trace_ok = 1'b1;
    noise_k = noise ? int'($urandom_range(1, d - 2)) : -1;
    scramble_mem();
    set_start(sel, 1'b1);
    @(posedge Clk); #1;
    for (int k = 0; k <= d; k++) begin
      if (k > 0) begin
        @(posedge Clk); #1;
      end
      set_start(sel, (k == noise_k));
      o = get_obs(sel);
      e_wdata = 32'd0;
      if (k < n) begin
        e_busy = 1; e_done = 0; e_regw = 1; e_wreg = first + k; e_wdata = pat(first + k);
        e_rr1 = 0; e_rr2 = 0;
      end else if (k < d) begin
        j = k - n;
        e_busy = 1; e_done = 0; e_regw = 0; e_wreg = 0;
        e_rr1 = first + 2 * j;
        e_rr2 = (first + 2 * j + 1 > last) ? last : first + 2 * j + 1;
      end else begin
        e_busy = 0; e_done = 1; e_regw = 0; e_wreg = 0; e_rr1 = 0; e_rr2 = 0;
      end
      if (trace_ok && (o.busy !== 1'(e_busy) || o.done !== 1'(e_done) ||
          o.regw !== 1'(e_regw) || o.wreg !== 5'(e_wreg) ||
          (e_regw != 0 && o.wdata !== e_wdata) ||
          o.rr1 !== 5'(e_rr1) || o.rr2 !== 5'(e_rr2))) begin
        trace_ok = 1'b0;
        $display("  %s diverged at edge %0d: busy=%0b done=%0b regw=%0b wreg=%0d wdata=%0h rr=%0d/%0d want %0d %0d %0d %0d %0h %0d/%0d",
                 tag, k, o.busy, o.done, o.regw, o.wreg, o.wdata, o.rr1, o.rr2,
                 e_busy, e_done, e_regw, e_wreg, e_wdata, e_rr1, e_rr2);
      end
    end
    check({"trace_", tag}, 64'(trace_ok), 64'd1);
    o = get_obs(sel);
    check({"pass_", tag}, 64'(o.pass), 64'(exp_pass));
    check({"errcnt_", tag}, 64'(o.ec), 64'(exp_ec));
    check({"firsterr_", tag}, 64'(o.fe), 64'(exp_fe));
    @(posedge Clk); #1;
    o = get_obs(sel);
    check({"done_held_", tag}, {62'd0, o.done, o.busy}, 64'd2);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int dk, ec, fe, sel, nf, first, last;

    Reset = 1'b0; start_a = 1'b1; start_b = 1'b1; scramble = 1'b0;
    clear_masks();

    // Reset held with Start high: everything stays zero.
    repeat (2) @(posedge Clk);
    #1;
    check("reset_a", 64'(get_obs(0)), 64'd0);
    check("reset_b", 64'(get_obs(1)), 64'd0);
    start_a = 1'b0; start_b = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    check("idle_a", 64'(get_obs(0)), 64'd0);

    //            sel r1 b1  r2 b2  pass ec fe
    tbl[0] = '{0, 0,  0,  0, 0,  1, 0, 0 };
    tbl[1] = '{0, 13, 3,  0, 0,  0, 1, 13};
    tbl[2] = '{0, 8,  0,  0, 0,  1, 0, 0 };   // stuck bit already 0 in pattern
    tbl[3] = '{0, 25, 0,  0, 0,  0, 1, 25};
    tbl[4] = '{0, 5,  0,  0, 0,  1, 0, 0 };   // outside tested range
    tbl[5] = '{0, 10, 1, 11, 1,  0, 2, 10};   // both ports fail together
    tbl[6] = '{0, 20, 31, 9, 0,  0, 2, 9 };
    tbl[7] = '{1, 0,  0,  0, 0,  1, 0, 0 };
    tbl[8] = '{1, 12, 2,  0, 0,  0, 1, 12};   // duplicated last pair
    tbl[9] = '{1, 9,  0,  0, 0,  0, 1, 9 };

    for (int i = 0; i < 10; i++) begin
      clear_masks();
      add_fault(tbl[i].sel, tbl[i].r1, tbl[i].b1);
      add_fault(tbl[i].sel, tbl[i].r2, tbl[i].b2);
      run_check(tbl[i].sel, 8, (tbl[i].sel == 0) ? 25 : 12,
                tbl[i].exp_pass, tbl[i].exp_ec, tbl[i].exp_fe, 1'b0,
                $sformatf("vec%0d", i));
    end

    // Reset at edge 10 of a run.
    clear_masks();
    scramble_mem();
    start_a = 1'b1;
    @(posedge Clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("midreset_regwrite", 64'(regw_a), 64'd0);
    check("midreset_all", 64'(get_obs(0)), 64'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midreset_stays_idle", 64'(get_obs(0)), 64'd0);
    run_check(0, 8, 25, 1, 0, 0, 1'b0, "after_reset");

    // Start held high through a run: Done for one cycle, then a fresh run.
    scramble_mem();
    start_a = 1'b1;
    dk = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge Clk); #1;
      if (done_a) begin
        dk = k;
        break;
      end
    end
    check("held_done_edge", 64'(dk), 64'd27);
    check("held_pass", 64'(pass_a), 64'd1);
    @(posedge Clk); #1;
    start_a = 1'b0;
    o = get_obs(0);
    check("held_restart", {59'd0, o.done, o.busy, o.regw, 2'b00} | 64'(o.wreg),
          {59'd0, 1'b0, 1'b1, 1'b1, 2'b00} | 64'd8);
    dk = -1;
    for (int k = 1; k < 60; k++) begin
      @(posedge Clk); #1;
      if (done_a) begin
        dk = k;
        break;
      end
    end
    check("held_rerun_edge", 64'(dk), 64'd27);
    check("held_rerun_pass", 64'(pass_a), 64'd1);

    // Randomised faults with stray Start pulses while busy.
    for (int it = 0; it < 8; it++) begin
      clear_masks();
      sel = int'($urandom_range(0, 1));
      first = 8;
      last = (sel == 0) ? 25 : 12;
      nf = int'($urandom_range(0, 3));
      for (int f = 0; f < nf; f++) begin
        add_fault(sel, int'($urandom_range(1, 31)), int'($urandom_range(0, 31)));
      end
      model(sel, first, last, ec, fe);
      run_check(sel, first, last, (ec == 0) ? 1 : 0, ec, fe, 1'b1,
                $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
